align_rd_scheduler: RTL and testbench
=====================================

Name: align_rd_scheduler

Overview:
- Shares one AXI read port (the path through the alignment stage to system memory) between NrReq requesters, e.g. per-cluster VLSU load units.
- Arbitrates AR requests round-robin and records the winner's index in an in-order route FIFO.
- Steers each returning R beat to the requester at the FIFO head.
- Pops the FIFO on each last beat, which caps outstanding bursts at NumOutstanding.

Parameters:
- NrReq, 4, number of requesters (>=2)
- NumOutstanding, 8, route FIFO depth and maximum in-flight bursts (power of 2)
- axi_ar_t, logic, AR channel payload type
- axi_r_t, logic, R channel payload type (has .last)
- idx_t (localparam), logic [$clog2(NrReq)-1:0], requester index

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_ar_valid_i  in  NrReq  per-requester AR valid
- req_ar_i  in  NrReq x axi_ar_t  per-requester AR payload
- req_ar_ready_o  out  NrReq  per-requester AR ready
- req_r_valid_o  out  NrReq  per-requester R valid
- req_r_o  out  axi_r_t  R payload, broadcast to all requesters
- req_r_ready_i  in  NrReq  per-requester R ready
- mem_ar_valid_o  out  1  shared AR valid
- mem_ar_o  out  axi_ar_t  shared AR payload
- mem_ar_ready_i  in  1  shared AR ready
- mem_r_valid_i  in  1  shared R valid
- mem_r_i  in  axi_r_t  shared R payload
- mem_r_ready_o  out  1  shared R ready
- busy_o  out  1  high while the FIFO is non-empty

Behaviour:
- Reset (async, active-high):
  - FIFO write/read pointers and count = 0; rr_ptr = 0; lock = 0; locked_idx = 0.
  - All valid/ready outputs = 0; busy_o = 0.
- Arbitration:
  - If lock = 0: winner = first asserted req_ar_valid_i starting at rr_ptr, wrapping modulo NrReq.
  - If lock = 1: winner = locked_idx.
  - mem_ar_valid_o = winner's valid AND NOT fifo_full.
  - mem_ar_o = winner's payload.
  - req_ar_ready_o[winner] = mem_ar_ready_i AND NOT fifo_full; all other bits 0.
  - AR path is combinational, zero added latency.
- Lock (AXI stability of the presented request):
  - If mem_ar_valid_o=1 and mem_ar_ready_i=0: lock=1 and locked_idx=winner next cycle.
  - Lock clears on the AR handshake.
  - Requester valid must not drop while locked; the bench asserts this.
- On AR handshake:
  - Push winner into the FIFO.
  - rr_ptr = (winner+1) mod NrReq.
- Full:
  - count == NumOutstanding forces mem_ar_valid_o = 0, even if a pop occurs the same cycle (no bypass).
  - A lock held before full persists; the request is re-presented once space frees.
- R routing:
  - head = FIFO[rd_ptr].
  - req_r_valid_o[head] = mem_r_valid_i AND NOT empty; all other bits 0.
  - mem_r_ready_o = req_r_ready_i[head] AND NOT empty.
  - req_r_o = mem_r_i.
- Empty: mem_r_ready_o = 0 and all req_r_valid_o = 0. An R beat while empty is a protocol error; the bench asserts it never happens.
- Pop: on R handshake with mem_r_i.last = 1.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointer wrap: pointers wrap modulo NumOutstanding. count is $clog2(NumOutstanding)+1 bits wide.
- busy_o = (count != 0), registered-derived.
- Reset mid-operation: all in-flight routing state is discarded; the system is reset together with this block.

Decomposition:
- ara_pkg: no new types. The idx_t width rule and NumOutstanding default go in the module header.
- Sub-module rr_arb_lock: round-robin arbiter with rr_ptr, lock and locked_idx state. The FIFO stays inline or uses fifo_v3 from common_cells.

Test Plan:
- Single requester 2 issues len=3 → one AR forwarded unchanged; 4 R beats reach only requester 2; FIFO pops on last; busy_o 1→0.
- All 4 requesters valid continuously, mem ready → grants in order 0,1,2,3,0; FIFO holds 0,1,2,3 in order.
- Requester 1 granted, mem_ar_ready_i low for 5 cycles while requester 0 also valid → grant held on 1 (lock); after handshake rr_ptr = 2.
- 8 ARs with no R returned → 9th AR blocked (mem_ar_valid_o = 0). Last beat of burst 0 accepted with an AR pending → AR blocked that cycle, issued next cycle.
- Head requester deasserts req_r_ready_i for 3 cycles mid-burst → mem_r_ready_o low for 3 cycles; no beat lost or duplicated.
- Reset asserted with 3 bursts outstanding → all outputs 0 immediately; count 0; fresh AR after reset routes correctly.

Source files
------------

// File: rtl/align_rd_scheduler_pkg.sv
// Shared defaults for the aligned-read scheduler.
// Holds the default requester count, route FIFO depth, default AXI
// payload types (overridden by the integrating design) and a width helper.
package align_rd_scheduler_pkg;

    localparam int unsigned DefNrReq          = 4;
    localparam int unsigned DefNumOutstanding = 8;

    // Default payloads; the R type must expose a .last field.
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
    } def_ar_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic        last;
    } def_r_t;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/align_rd_scheduler_rr_arb_lock.sv
// Round-robin arbiter with request lock.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        per-requester request valid
//   block_i        suppresses presentation (downstream full)
//   ready_i        downstream ready for the presented request
//   winner_o       selected requester index
//   win_valid_o    valid bit of the selected requester
// Once a request is presented without being accepted, the grant is pinned
// to that requester until the handshake so the downstream payload is stable.
module rr_arb_lock #(
    parameter int unsigned NrReq = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NrReq-1:0] valid_i,
    input  logic             block_i,
    input  logic             ready_i,
    output logic [IdxW-1:0]  winner_o,
    output logic             win_valid_o
);

    typedef logic [IdxW-1:0] idx_t;

    idx_t rr_ptr_q, rr_ptr_d;
    idx_t locked_idx_q, locked_idx_d;
    logic lock_q, lock_d;
    idx_t search_idx;
    logic found;
    logic presented, hs;

    // First asserted valid at or after rr_ptr, wrapping modulo NrReq.
    always_comb begin
        found      = 1'b0;
        search_idx = rr_ptr_q;
        for (int k = 0; k < int'(NrReq); k++) begin
            int c;
            c = int'(rr_ptr_q) + k;
            if (c >= int'(NrReq)) c = c - int'(NrReq);
            if (!found && valid_i[c]) begin
                found      = 1'b1;
                search_idx = idx_t'(c);
            end
        end
    end

    assign winner_o    = lock_q ? locked_idx_q : search_idx;
    assign win_valid_o = valid_i[winner_o];
    assign presented   = win_valid_o & ~block_i;
    assign hs          = presented & ready_i;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
        if (hs) begin
            lock_d   = 1'b0;
            rr_ptr_d = (winner_o == idx_t'(NrReq - 1)) ? '0 : winner_o + idx_t'(1);
        end else if (presented) begin
            lock_d       = 1'b1;
            locked_idx_d = winner_o;
        end
        // While blocked the lock is left untouched and re-presented later.
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
        end
    end

endmodule

// File: rtl/align_rd_scheduler.sv
// Shares one AXI read port between NrReq requesters.
// AR requests are arbitrated round-robin (with lock for AXI stability); the
// winner index is pushed into an in-order route FIFO which steers returning
// R beats to the requester at its head; the FIFO pops on each last beat.
// Parameters: NrReq (>=2, default 4), NumOutstanding (power of 2, default 8);
// idx_t is logic [$clog2(NrReq)-1:0].
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   req_ar_valid_i/req_ar_i/_ready_o  per-requester AR channels
//   req_r_valid_o/req_r_ready_i       per-requester R handshake
//   req_r_o                           R payload broadcast to all requesters
//   mem_ar_*/mem_r_*                  shared memory-side AXI read port
//   busy_o                            route FIFO non-empty
module align_rd_scheduler
    import align_rd_scheduler_pkg::*;
#(
    parameter int unsigned NrReq          = DefNrReq,
    parameter int unsigned NumOutstanding = DefNumOutstanding,
    parameter type         axi_ar_t       = def_ar_t,
    parameter type         axi_r_t        = def_r_t
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NrReq-1:0] req_ar_valid_i,
    input  axi_ar_t          req_ar_i [NrReq],
    output logic [NrReq-1:0] req_ar_ready_o,
    output logic [NrReq-1:0] req_r_valid_o,
    output axi_r_t           req_r_o,
    input  logic [NrReq-1:0] req_r_ready_i,
    output logic             mem_ar_valid_o,
    output axi_ar_t          mem_ar_o,
    input  logic             mem_ar_ready_i,
    input  logic             mem_r_valid_i,
    input  axi_r_t           mem_r_i,
    output logic             mem_r_ready_o,
    output logic             busy_o
);

    localparam int unsigned IdxW = idx_w(NrReq);
    localparam int unsigned PtrW = idx_w(NumOutstanding);
    localparam int unsigned CntW = $clog2(NumOutstanding) + 1;

    typedef logic [IdxW-1:0] idx_t;

    idx_t            route_q [NumOutstanding];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    idx_t winner, head;
    logic win_valid, fifo_full, fifo_empty;
    logic ar_hs, pop;

    assign fifo_full  = (cnt_q == CntW'(NumOutstanding));
    assign fifo_empty = (cnt_q == '0);

    rr_arb_lock #(
        .NrReq (NrReq),
        .IdxW  (IdxW)
    ) i_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (req_ar_valid_i),
        .block_i     (fifo_full),
        .ready_i     (mem_ar_ready_i),
        .winner_o    (winner),
        .win_valid_o (win_valid)
    );

    // AR path: combinational; full blocks even when a pop is in flight.
    // Reset forces the outputs low regardless of requester inputs.
    assign mem_ar_valid_o = win_valid & ~fifo_full & ~rst_i;
    assign mem_ar_o       = req_ar_i[winner];
    assign ar_hs          = mem_ar_valid_o & mem_ar_ready_i;

    always_comb begin
        req_ar_ready_o = '0;
        if (!fifo_full && !rst_i) req_ar_ready_o[winner] = mem_ar_ready_i;
    end

    // R path: steer to the requester whose burst is oldest.
    assign head          = route_q[rd_ptr_q];
    assign req_r_o       = mem_r_i;
    assign mem_r_ready_o = ~fifo_empty & req_r_ready_i[head];
    assign pop           = mem_r_valid_i & mem_r_ready_o & mem_r_i.last;

    always_comb begin
        req_r_valid_o = '0;
        if (!fifo_empty) req_r_valid_o[head] = mem_r_valid_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (ar_hs) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (ar_hs && !pop)      cnt_d = cnt_q + CntW'(1);
        else if (pop && !ar_hs) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Route storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk_i) begin
        if (ar_hs) route_q[wr_ptr_q] <= winner;
    end

    assign busy_o = ~fifo_empty;

endmodule

// File: tb/tb_align_rd_scheduler.sv
module tb_align_rd_scheduler;

    localparam int NR = 4;
    localparam int NO = 8;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  len;
        logic [3:0]  id;
    } ar_t;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } r_t;

    logic          clk, rst;
    logic [NR-1:0] req_ar_valid_i, req_ar_ready_o, req_r_valid_o, req_r_ready_i;
    ar_t           req_ar_i [NR];
    r_t            req_r_o, mem_r_i;
    ar_t           mem_ar_o;
    logic          mem_ar_valid_o, mem_ar_ready_i, mem_r_valid_i, mem_r_ready_o, busy_o;

    align_rd_scheduler #(
        .NrReq          (NR),
        .NumOutstanding (NO),
        .axi_ar_t       (ar_t),
        .axi_r_t        (r_t)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_ar_valid_i (req_ar_valid_i),
        .req_ar_i       (req_ar_i),
        .req_ar_ready_o (req_ar_ready_o),
        .req_r_valid_o  (req_r_valid_o),
        .req_r_o        (req_r_o),
        .req_r_ready_i  (req_r_ready_i),
        .mem_ar_valid_o (mem_ar_valid_o),
        .mem_ar_o       (mem_ar_o),
        .mem_ar_ready_i (mem_ar_ready_i),
        .mem_r_valid_i  (mem_r_valid_i),
        .mem_r_i        (mem_r_i),
        .mem_r_ready_o  (mem_r_ready_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state: requester agents, memory agent, routing order.
    logic [NR-1:0] rv;
    ar_t           ar_pl [NR];
    int            route_q [$];   // requester index of each outstanding burst, oldest first
    int            beats_q [$];   // beats still owed for each outstanding burst
    int            rr;
    bit            lock;
    int            lidx;
    logic          rvld;
    r_t            rpl;

    task automatic model_clear();
        route_q.delete();
        beats_q.delete();
        rr   = 0;
        lock = 0;
        lidx = 0;
        rv   = '0;
        rvld = 1'b0;
        rpl  = '0;
    endtask

    task automatic drive_idle();
        req_ar_valid_i = '0;
        for (int i = 0; i < NR; i++) req_ar_i[i] = '0;
        req_r_ready_i  = '0;
        mem_ar_ready_i = 1'b0;
        mem_r_valid_i  = 1'b0;
        mem_r_i        = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ar_valid"}, 64'(mem_ar_valid_o), 64'(0));
        chk({tag, "_ar_ready"}, 64'(req_ar_ready_o), 64'(0));
        chk({tag, "_r_valid"},  64'(req_r_valid_o),  64'(0));
        chk({tag, "_r_ready"},  64'(mem_r_ready_o),  64'(0));
        chk({tag, "_busy"},     64'(busy_o),         64'(0));
    endtask

    // Called just after a posedge; requesters stay valid to show reset gating.
    task automatic mid_reset();
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        model_clear();
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int p_req, input int p_ardy,
                       input int p_rv, input int p_rrdy);
        for (int cyc = 0; cyc < n; cyc++) begin
            int   w, head;
            bit   full, empty, exp_av, ar_hs, r_hs;
            logic [NR-1:0] exp_ardy, exp_rv;
            logic exp_rr;

            // Requester agents: new request only when idle, held until accepted.
            for (int i = 0; i < NR; i++) begin
                if (!rv[i] && $urandom_range(99) < p_req) begin
                    rv[i]       = 1'b1;
                    ar_pl[i]    = '0;
                    ar_pl[i].addr = 16'($urandom);
                    ar_pl[i].len  = 4'($urandom_range(3));
                    ar_pl[i].id   = 4'(i);
                end
            end
            req_ar_valid_i = rv;
            for (int i = 0; i < NR; i++) req_ar_i[i] = ar_pl[i];
            mem_ar_ready_i = ($urandom_range(99) < p_ardy);

            // Memory agent returns beats in AR order, holding each until taken.
            if (!rvld && beats_q.size() > 0 && $urandom_range(99) < p_rv) begin
                rvld      = 1'b1;
                rpl.data  = 16'($urandom);
                rpl.last  = (beats_q[0] == 1);
            end
            mem_r_valid_i = rvld;
            mem_r_i       = rpl;
            for (int i = 0; i < NR; i++) req_r_ready_i[i] = ($urandom_range(99) < p_rrdy);

            #4;
            full  = (route_q.size() == NO);
            empty = (route_q.size() == 0);

            w = rr;
            if (lock) w = lidx;
            else begin
                for (int k = 0; k < NR; k++) begin
                    if (rv[(rr + k) % NR]) begin
                        w = (rr + k) % NR;
                        break;
                    end
                end
            end
            exp_av   = rv[w] && !full;
            exp_ardy = '0;
            if (!full) exp_ardy[w] = mem_ar_ready_i;

            head   = empty ? 0 : route_q[0];
            exp_rv = '0;
            exp_rr = 1'b0;
            if (!empty) begin
                exp_rv[head] = rvld;
                exp_rr       = req_r_ready_i[head];
            end

            assert (!(lock && !rv[lidx])) else $error("requester dropped valid while locked");
            assert (!(rvld && empty)) else $error("R beat returned with no outstanding burst");

            chk("ar_valid", 64'(mem_ar_valid_o), 64'(exp_av));
            chk("ar_ready", 64'(req_ar_ready_o), 64'(exp_ardy));
            if (exp_av) chk("ar_payload", 64'(mem_ar_o), 64'(ar_pl[w]));
            chk("r_valid",  64'(req_r_valid_o),  64'(exp_rv));
            chk("r_ready",  64'(mem_r_ready_o),  64'(exp_rr));
            chk("r_payload", 64'(req_r_o),       64'(rpl));
            chk("busy",     64'(busy_o),         64'(!empty));

            ar_hs = exp_av && mem_ar_ready_i;
            r_hs  = !empty && rvld && req_r_ready_i[head];
            if (r_hs) begin
                rvld = 1'b0;
                beats_q[0] = beats_q[0] - 1;
                if (beats_q[0] == 0) begin
                    void'(beats_q.pop_front());
                    void'(route_q.pop_front());
                end
            end
            if (ar_hs) begin
                route_q.push_back(w);
                beats_q.push_back(int'(ar_pl[w].len) + 1);
                rr    = (w + 1) % NR;
                lock  = 0;
                rv[w] = 1'b0;
            end else if (exp_av) begin
                lock = 1;
                lidx = w;
            end

            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        drive_idle();
        #1;
        chk_reset_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        run(400, 50, 70, 60, 80);   // mixed traffic
        run(60, 80, 100, 0, 100);   // no returns: fill to full, AR blocked
        run(200, 30, 80, 90, 70);   // drain under contention
        run(300, 90, 20, 70, 40);   // slow AR ready: lock holds
        run(30, 100, 100, 0, 100);  // build outstanding bursts
        mid_reset();
        run(300, 60, 50, 70, 50);   // traffic after reset
        run(100, 20, 30, 40, 30);
        run(300, 100, 100, 100, 100); // back-to-back, pop and push together

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
